// File: rtl/ifetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage. Decode uses the same
// instruction width, PC width and bubble encoding.
package ifetch_unit_pkg;

    localparam int          IFU_PC_W     = 8;
    localparam int          IFU_INST_W   = 16;
    localparam int          IFU_DEPTH    = 2;
    localparam logic [7:0]  IFU_RESET_PC = 8'h00;
    localparam logic [15:0] IFU_INST_NOP = 16'hF000;

    // Width of a counter that must hold every value from 0 to depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifetch_unit_ifq_fifo.sv
// Small synchronous FIFO with combinational head read, occupancy count and a
// synchronous clear. Used for both the prefetch queue and the PC tag queue.
module ifq_fifo
    import ifetch_unit_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 2,
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next pointer and occupancy; clear wins over push/pop.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the count alone says which entries are live.
        if (push && !clr && !rst) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues word reads to
// instruction memory under a credit limit, buffers responses in a prefetch
// queue and presents the head to decode. A branch redirect flushes the queue
// and discards every read that is still outstanding.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int              PC_W     = IFU_PC_W,
    parameter int              INST_W   = IFU_INST_W,
    parameter int              DEPTH    = IFU_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFU_RESET_PC),
    parameter logic [INST_W-1:0] INST_NOP = INST_W'(IFU_INST_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [PC_W-1:0]   br_target,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic [PC_W-1:0]   pc_out
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int USE_W = CNT_W + 1;
    localparam int ENT_W = PC_W + INST_W;

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    // The tag queue occupancy is the number of reads granted but not yet returned.
    logic [CNT_W-1:0] inflight;
    logic [PC_W-1:0]  tag_pc;
    logic [CNT_W-1:0] q_count;
    logic [ENT_W-1:0] q_head;
    logic [USE_W-1:0] used;

    logic grant;
    logic resp;
    logic discard;
    logic q_push;
    logic q_pop;

    // Dropped reads keep consuming credit until they come back.
    assign used      = USE_W'(q_count) + USE_W'(inflight);
    assign imem_req  = !rst && !br_valid && (used < USE_W'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;

    // A response with nothing outstanding is spurious and ignored.
    assign resp    = imem_rvalid && (inflight != '0);
    assign discard = (drop_q != '0);

    assign inst_valid = (q_count != '0);
    assign q_push     = resp && !discard && !br_valid;
    assign q_pop      = inst_valid && !stall && !br_valid;

    // Fetch PC and pending-discard counter; a redirect overrides both.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        if (grant)          fetch_pc_d = fetch_pc_q + PC_W'(1);
        if (resp && discard) drop_d    = drop_q - CNT_W'(1);
        if (br_valid) begin
            fetch_pc_d = br_target;
            drop_d     = inflight - CNT_W'(resp);
        end
    end

    // Fetch PC and discard counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
        end
    end

    // Address of each granted read, retired in order as responses arrive.
    ifq_fifo #(
        .WIDTH (PC_W),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .push  (grant),
        .wdata (fetch_pc_q),
        .pop   (resp),
        .rdata (tag_pc),
        .count (inflight)
    );

    // Prefetch queue of {pc, inst} feeding decode.
    ifq_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk   (clk),
        .rst   (rst),
        .clr   (br_valid),
        .push  (q_push),
        .wdata ({tag_pc, imem_rdata}),
        .pop   (q_pop),
        .rdata (q_head),
        .count (q_count)
    );

    assign inst   = inst_valid ? q_head[INST_W-1:0]     : INST_NOP;
    assign pc_out = inst_valid ? q_head[INST_W+:PC_W]  : '0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a behavioural instruction memory whose
// response latency is adjustable per scenario.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        br_valid;
    logic [7:0]  br_target;
    logic [15:0] inst;
    logic        inst_valid;
    logic [7:0]  pc_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int mem_lat = 1;

    logic [7:0] pend_addr[$];
    int         pend_due[$];
    logic [7:0] grants[$];

    ifetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .pc_out      (pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        case (a)
            8'h00:   return 16'h1010;
            8'h01:   return 16'hC188;
            8'h02:   return 16'hA148;
            default: return {a ^ 8'hA5, a};
        endcase
    endfunction

    // One clock: note any grant before the edge, then drive the memory response 1 ns after it.
    task automatic tick();
        #2;
        if (imem_req && imem_gnt) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + mem_lat);
            grants.push_back(imem_addr);
        end
        @(posedge clk);
        cyc++;
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        br_valid    = 1'b0;
        br_target   = 8'h00;
        stall       = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        pend_addr.delete();
        pend_due.delete();
        grants.delete();
        tick();
        tick();
    endtask

    task automatic test_reset();
        mem_lat = 1;
        do_reset();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
        checks++; if (inst !== 16'hF000) begin errors++; $display("FAIL reset_inst got %h exp f000", inst); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
        checks++; if (pc_out !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", pc_out); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL issue_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL issue_addr got %h exp 00", imem_addr); end
    endtask

    task automatic test_basic();
        logic [15:0] exp_i [3];
        logic [7:0]  exp_p [3];
        logic [15:0] got_i [3];
        logic [7:0]  got_p [3];
        int n;
        exp_i = '{16'h1010, 16'hC188, 16'hA148};
        exp_p = '{8'h00, 8'h01, 8'h02};
        mem_lat = 1;
        do_reset();
        rst = 1'b0;
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_edge1 got %b exp 0", inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_edge2 got %b exp 1", inst_valid); end
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            if (inst_valid) begin
                got_i[n] = inst;
                got_p[n] = pc_out;
                n++;
            end
            tick();
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL basic_count got %0d exp 3", n); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (got_i[k] !== exp_i[k]) begin errors++; $display("FAIL basic_inst%0d got %h exp %h", k, got_i[k], exp_i[k]); end
            checks++; if (got_p[k] !== exp_p[k]) begin errors++; $display("FAIL basic_pc%0d got %h exp %h", k, got_p[k], exp_p[k]); end
        end
    endtask

    task automatic test_stall();
        mem_lat = 1;
        do_reset();
        rst = 1'b0;
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (inst !== 16'h1010 || inst_valid !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got %h/%b exp 1010/1", i, inst, inst_valid); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req%0d got %b exp 0", i, imem_req); end
        end
        stall = 1'b0;
        tick();
        checks++; if (inst !== 16'hC188 || pc_out !== 8'h01) begin errors++; $display("FAIL stall_rel1 got %h@%h exp c188@01", inst, pc_out); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (inst_valid) break;
        end
        checks++; if (inst !== 16'hA148 || pc_out !== 8'h02) begin errors++; $display("FAIL stall_rel2 got %h@%h exp a148@02", inst, pc_out); end
    endtask

    task automatic test_redirect();
        mem_lat = 3;
        do_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_credit got %b exp 0", imem_req); end
        br_valid  = 1'b1;
        br_target = 8'h40;
        grants.delete();
        tick();
        br_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (inst_valid) break;
            tick();
        end
        checks++; if (pc_out !== 8'h40) begin errors++; $display("FAIL redir_pc got %h exp 40", pc_out); end
        checks++; if (inst !== 16'hE540) begin errors++; $display("FAIL redir_inst got %h exp e540", inst); end
        checks++; if (grants.size() == 0 || grants[0] !== 8'h40) begin errors++; $display("FAIL redir_addr got %0d grants exp first 40", grants.size()); end
        mem_lat = 1;
    endtask

    task automatic test_gnt_hold();
        mem_lat = 1;
        do_reset();
        rst = 1'b0;
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL gnt_hold%0d got %b/%h exp 1/00", i, imem_req, imem_addr); end
        end
        imem_gnt = 1'b1;
        tick();
        checks++; if (imem_addr !== 8'h01) begin errors++; $display("FAIL gnt_advance got %h exp 01", imem_addr); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_w [3];
        exp_w = '{8'hFE, 8'hFF, 8'h00};
        mem_lat = 1;
        do_reset();
        rst       = 1'b0;
        br_valid  = 1'b1;
        br_target = 8'hFE;
        tick();
        br_valid = 1'b0;
        grants.delete();
        for (int i = 0; i < 20 && grants.size() < 3; i++) tick();
        checks++; if (grants.size() < 3) begin errors++; $display("FAIL wrap_count got %0d exp 3", grants.size()); end
        for (int k = 0; k < 3 && k < grants.size(); k++) begin
            checks++; if (grants[k] !== exp_w[k]) begin errors++; $display("FAIL wrap_addr%0d got %h exp %h", k, grants[k], exp_w[k]); end
        end
    endtask

    task automatic test_reset_midstream();
        mem_lat = 3;
        do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        pend_addr.delete();
        pend_due.delete();
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hDEAD;
        tick();
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_req_valid got %b/%b exp 0/0", imem_req, inst_valid); end
        checks++; if (inst !== 16'hF000 || pc_out !== 8'h00) begin errors++; $display("FAIL mid_rst_out got %h@%h exp f000@00", inst, pc_out); end
        rst         = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hBEEF;
        tick();
        checks++; if (inst_valid !== 1'b0 || inst !== 16'hF000) begin errors++; $display("FAIL late_rvalid got %b/%h exp 0/f000", inst_valid, inst); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL mid_restart got %b/%h exp 1/00", imem_req, imem_addr); end
        mem_lat  = 1;
        imem_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (inst_valid) break;
        end
        checks++; if (inst !== 16'h1010 || pc_out !== 8'h00) begin errors++; $display("FAIL mid_first got %h@%h exp 1010@00", inst, pc_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_gnt_hold();
        test_wrap();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
